// File: rtl/game_pkg.sv
// Shared state encoding and width helpers for the game flow controller.
package game_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] INIT  = 3'd0;
  localparam logic [STATE_W-1:0] RUN   = 3'd1;
  localparam logic [STATE_W-1:0] HIT   = 3'd2;
  localparam logic [STATE_W-1:0] PAUSE = 3'd3;
  localparam logic [STATE_W-1:0] DEAD  = 3'd4;

  // Width of a counter holding 0..n
  function automatic int lives_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of a counter holding 0..n-1
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous level, flags a 0->1 change.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow FSM: lives, post-hit invulnerability, pause, restart hold-off,
// and saturating score / high-score counters. All outputs registered.
//   state | meaning
//   INIT  | waiting for a jump edge to start a game
//   RUN   | world scrolling, collisions cost a life
//   HIT   | invulnerable respawn window, world still scrolling
//   PAUSE | world frozen until the next pause edge
//   DEAD  | no lives left, restart allowed after hold-off
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LIVES      = 3,
  parameter int RESPAWN_CYCLES = 60,
  parameter int DEAD_HOLDOFF   = 30,
  parameter int SCORE_DIV      = 6,
  parameter int SCORE_W        = 14,
  localparam int LIVES_W       = lives_w(NUM_LIVES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump,
  input  logic               pause,
  input  logic               collided,
  output logic [STATE_W-1:0] state,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               run_en,
  output logic               start_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score
);

  localparam int TMR_MAX = (RESPAWN_CYCLES > DEAD_HOLDOFF) ? RESPAWN_CYCLES : DEAD_HOLDOFF;
  localparam int TMR_W   = cnt_w(TMR_MAX);
  localparam int DIV_W   = cnt_w(SCORE_DIV);

  localparam logic [TMR_W-1:0]   RESPAWN_LOAD = TMR_W'(RESPAWN_CYCLES - 1);
  localparam logic [TMR_W-1:0]   HOLDOFF_LOAD = TMR_W'(DEAD_HOLDOFF - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(NUM_LIVES);
  localparam logic [DIV_W-1:0]   DIV_LAST     = DIV_W'(SCORE_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX    = {SCORE_W{1'b1}};

  logic               jump_rise, pause_rise;
  logic [STATE_W-1:0] state_nx;
  logic [LIVES_W-1:0] lives_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic [DIV_W-1:0]   div, div_nx;
  logic [SCORE_W-1:0] score_nx, hi_nx;
  logic               start_nx, clear_score;

  rise_detect u_jump_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (jump),
    .rise (jump_rise)
  );

  rise_detect u_pause_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (pause),
    .rise (pause_rise)
  );

  always_comb begin
    state_nx    = state;
    lives_nx    = lives;
    timer_nx    = timer;
    start_nx    = 1'b0;
    clear_score = 1'b0;
    case (state)
      INIT: begin
        if (jump_rise) begin
          state_nx    = RUN;
          lives_nx    = LIVES_INIT;
          start_nx    = 1'b1;
          clear_score = 1'b1;
        end
      end
      RUN: begin
        if (collided) begin
          if (lives > LIVES_W'(1)) begin
            state_nx = HIT;
            lives_nx = lives - LIVES_W'(1);
            timer_nx = RESPAWN_LOAD;
          end else begin
            state_nx = DEAD;
            lives_nx = '0;
            timer_nx = HOLDOFF_LOAD;
          end
        end else if (pause_rise) begin
          state_nx = PAUSE;
        end
      end
      HIT: begin
        if (timer == '0) state_nx = RUN;
        else             timer_nx = timer - TMR_W'(1);
      end
      PAUSE: begin
        if (pause_rise) state_nx = RUN;
      end
      DEAD: begin
        // Edges during hold-off are dropped; a held button never restarts.
        if (timer != '0)    timer_nx = timer - TMR_W'(1);
        else if (jump_rise) state_nx = INIT;
      end
      default: begin
        state_nx = INIT;
        timer_nx = '0;
      end
    endcase
  end

  always_comb begin
    div_nx   = div;
    score_nx = score;
    if (clear_score) begin
      div_nx   = '0;
      score_nx = '0;
    end else if (run_en) begin
      if (div == DIV_LAST) begin
        div_nx = '0;
        if (score != SCORE_MAX) score_nx = score + SCORE_W'(1);
      end else begin
        div_nx = div + DIV_W'(1);
      end
    end
    // Latch on DEAD entry using the score including this cycle's increment.
    hi_nx = hi_score;
    if ((state_nx == DEAD) && (state != DEAD) && (score_nx > hi_score))
      hi_nx = score_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      lives       <= LIVES_INIT;
      invuln      <= 1'b0;
      run_en      <= 1'b0;
      start_pulse <= 1'b0;
      score       <= '0;
      hi_score    <= '0;
      timer       <= '0;
      div         <= '0;
    end else begin
      state       <= state_nx;
      lives       <= lives_nx;
      invuln      <= (state_nx == HIT);
      run_en      <= (state_nx == RUN) || (state_nx == HIT);
      start_pulse <= start_nx;
      score       <= score_nx;
      hi_score    <= hi_nx;
      timer       <= timer_nx;
      div         <= div_nx;
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a default instance and a 4-bit-score
// instance share stimulus so saturation is observed alongside exact scores.
module tb_game_flow_ctrl;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst, jump, pause, collided;
  logic [2:0]  state, state_s;
  logic [1:0]  lives, lives_s;
  logic        invuln, invuln_s, run_en, run_en_s, start_pulse, start_s;
  logic [13:0] score, hi_score;
  logic [3:0]  score_s, hi_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_flow_ctrl dut (
    .clk(clk), .rst(rst), .jump(jump), .pause(pause), .collided(collided),
    .state(state), .lives(lives), .invuln(invuln), .run_en(run_en),
    .start_pulse(start_pulse), .score(score), .hi_score(hi_score)
  );

  game_flow_ctrl #(.SCORE_W(4)) dut_s (
    .clk(clk), .rst(rst), .jump(jump), .pause(pause), .collided(collided),
    .state(state_s), .lives(lives_s), .invuln(invuln_s), .run_en(run_en_s),
    .start_pulse(start_s), .score(score_s), .hi_score(hi_s)
  );

  typedef struct {
    logic       j, p, c;
    logic [2:0] st;
    int         lv;
    logic       inv, ren, sp;
    int         sc;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mkv(logic j, logic p, logic c, logic [2:0] st, int lv,
                               logic inv, logic ren, logic sp, int sc);
    vec_t v;
    v.j = j; v.p = p; v.c = c; v.st = st; v.lv = lv;
    v.inv = inv; v.ren = ren; v.sp = sp; v.sc = sc;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, state, INIT);
    chk({tag, "_lives"}, lives, 3);
    chk({tag, "_invuln"}, invuln, 0);
    chk({tag, "_run_en"}, run_en, 0);
    chk({tag, "_start"}, start_pulse, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_hi"}, hi_score, 0);
    chk({tag, "_s_state"}, state_s, INIT);
    chk({tag, "_s_lives"}, lives_s, 3);
    chk({tag, "_s_flags"}, {invuln_s, run_en_s, start_s}, 0);
    chk({tag, "_s_score"}, score_s, 0);
    chk({tag, "_s_hi"}, hi_s, 0);
  endtask

  task automatic chk_dead(input string tag, input int sc, input int hi);
    chk({tag, "_state"}, state, DEAD);
    chk({tag, "_lives"}, lives, 0);
    chk({tag, "_run_en"}, run_en, 0);
    chk({tag, "_invuln"}, invuln, 0);
    chk({tag, "_score"}, score, sc);
    chk({tag, "_hi"}, hi_score, hi);
    chk({tag, "_s_score"}, score_s, 15);
    chk({tag, "_s_hi"}, hi_s, 15);
  endtask

  task automatic wait_hit_over(input string tag);
    int guard = 0;
    while (state == HIT && guard < 200) begin
      guard++;
      step(1);
    end
    chk({tag, "_hit_len"}, guard, 60);
    chk({tag, "_back_run"}, state, RUN);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; jump = 1'b0; pause = 1'b0; collided = 1'b0;
    step(2);
    chk_reset("rst");
    rst = 1'b0;

    vecs[0]  = mkv(0, 0, 0, INIT,  3, 0, 0, 0, 0);
    vecs[1]  = mkv(1, 0, 0, RUN,   3, 0, 1, 1, 0);
    vecs[2]  = mkv(1, 0, 0, RUN,   3, 0, 1, 0, 0);
    vecs[3]  = mkv(0, 0, 0, RUN,   3, 0, 1, 0, 0);
    vecs[4]  = mkv(1, 0, 0, RUN,   3, 0, 1, 0, 0);
    vecs[5]  = mkv(0, 0, 0, RUN,   3, 0, 1, 0, 0);
    vecs[6]  = mkv(0, 1, 0, PAUSE, 3, 0, 0, 0, 0);
    vecs[7]  = mkv(0, 1, 1, PAUSE, 3, 0, 0, 0, 0);
    vecs[8]  = mkv(0, 0, 0, PAUSE, 3, 0, 0, 0, 0);
    vecs[9]  = mkv(0, 1, 0, RUN,   3, 0, 1, 0, 0);
    vecs[10] = mkv(0, 0, 0, RUN,   3, 0, 1, 0, 1);

    for (int i = 0; i < 11; i++) begin
      jump = vecs[i].j; pause = vecs[i].p; collided = vecs[i].c;
      step(1);
      chk($sformatf("v%0d_state", i), state, vecs[i].st);
      chk($sformatf("v%0d_lives", i), lives, vecs[i].lv);
      chk($sformatf("v%0d_invuln", i), invuln, vecs[i].inv);
      chk($sformatf("v%0d_run_en", i), run_en, vecs[i].ren);
      chk($sformatf("v%0d_start", i), start_pulse, vecs[i].sp);
      chk($sformatf("v%0d_score", i), score, vecs[i].sc);
      chk($sformatf("v%0d_s_score", i), score_s, vecs[i].sc);
    end
    pause = 1'b0;

    step(60);
    chk("run60_score", score, 11);
    chk("run60_s_score", score_s, 11);
    step(240);
    chk("run300_score", score, 51);
    chk("sat_s_score", score_s, 15);

    // First hit with collided held: only one life lost, 60-cycle window.
    collided = 1'b1;
    step(1);
    chk("hit1_state", state, HIT);
    chk("hit1_lives", lives, 2);
    chk("hit1_invuln", invuln, 1);
    chk("hit1_run_en", run_en, 1);
    cnt = 0;
    while (invuln && cnt < 200) begin
      cnt++;
      if (cnt == 5)  collided = 1'b0;
      if (cnt == 60) collided = 1'b1;
      step(1);
    end
    chk("hit1_len", cnt, 60);
    chk("hit1_exit_state", state, RUN);
    chk("hit1_exit_lives", lives, 2);

    // Collision on the expiry cycle was ignored; still high now, so it counts.
    step(1);
    chk("hit2_state", state, HIT);
    chk("hit2_lives", lives, 1);
    collided = 1'b0;
    wait_hit_over("hit2");
    step(3);
    collided = 1'b1;
    step(1);
    collided = 1'b0;
    chk_dead("dead1", 72, 72);

    // Hold-off: early edges and a held level are all rejected.
    step(9);
    jump = 1'b1;
    step(1);
    chk("dead1_early_edge", state, DEAD);
    jump = 1'b0;
    step(18);
    jump = 1'b1;
    step(1);
    chk("dead1_last_edge", state, DEAD);
    step(30);
    chk("dead1_held", state, DEAD);
    jump = 1'b0;
    step(1);
    jump = 1'b1;
    step(1);
    chk("dead1_restart", state, INIT);
    chk("dead1_restart_score", score, 72);

    jump = 1'b0;
    step(1);
    jump = 1'b1;
    step(1);
    chk("g2_state", state, RUN);
    chk("g2_start", start_pulse, 1);
    chk("g2_lives", lives, 3);
    chk("g2_score", score, 0);
    chk("g2_hi", hi_score, 72);
    jump = 1'b0;
    step(1);
    chk("g2_start_off", start_pulse, 0);
    collided = 1'b1;
    step(1);
    collided = 1'b0;
    chk("g2_hit1_lives", lives, 2);
    wait_hit_over("g2_hit1");
    collided = 1'b1;
    step(1);
    collided = 1'b0;
    chk("g2_hit2_lives", lives, 1);
    wait_hit_over("g2_hit2");
    collided = 1'b1;
    step(1);
    collided = 1'b0;
    chk_dead("dead2", 20, 72);

    // First edge accepted exactly when the hold-off timer reaches zero.
    step(29);
    jump = 1'b1;
    step(1);
    chk("dead2_restart", state, INIT);

    jump = 1'b0;
    step(1);
    jump = 1'b1;
    step(1);
    jump = 1'b0;
    collided = 1'b1;
    step(1);
    collided = 1'b0;
    chk("g3_hit", state, HIT);
    step(5);
    rst = 1'b1;
    step(1);
    chk_reset("midhit_rst");
    rst = 1'b0;
    step(1);
    chk("post_rst_state", state, INIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
